// File: rtl/uart_native_responder_if.sv
// Single-beat valid/ready register bus between the interconnect and the UART responder.
interface uart_native_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/uart_native_responder.sv
// 8N1 UART behind a register bus: access completes with a ready pulse one cycle after valid,
// no stalls; a new access is only taken while ready is low.
module uart_native_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_native_responder_if.slave bus,
    output logic                   txd,
    input  logic                   rxd
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    localparam logic [ADDR_W-1:0] A_SRST = 3'd0, A_DIV = 3'd1, A_TXDATA = 3'd2, A_TXEN = 3'd3,
                                  A_RXEN = 3'd4, A_TXRDY = 3'd5, A_RXRDY = 3'd6, A_RXDATA = 3'd7;

    uart_state_e       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DIV_W-1:0]  div_q, div_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rxdata_q, rxdata_d;
    logic              txd_q, txd_d, txen_q, txen_d, rxen_q, rxen_d, rxrdy_q, rxrdy_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0]  div_eff, div_half;
    logic              accept, wr, rd, tx_rdy, rx_done;
    logic              unused_wdata;

    assign div_eff      = (div_q == '0) ? DIV_W'(1) : div_q;
    assign div_half     = ((div_eff >> 1) == '0) ? DIV_W'(1) : (div_eff >> 1);
    assign accept       = bus.valid && !ready_q;
    assign wr           = accept && (|bus.wstrb);
    assign rd           = accept && !(|bus.wstrb);
    assign tx_rdy       = txen_q && (tx_state_q == S_IDLE);
    assign unused_wdata = ^bus.wdata[DATA_W-1:DIV_W];

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign txd       = txd_q;

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            A_TXRDY:  rd_val[0]   = tx_rdy;
            A_RXRDY:  rd_val[0]   = rxrdy_q;
            A_RXDATA: rd_val[7:0] = rxdata_q;
            default:  rd_val      = '0;
        endcase
    end

    always_comb begin
        ready_d    = accept;
        rdata_d    = rd ? rd_val : '0;
        div_d      = div_q;
        txen_d     = txen_q;
        rxen_d     = rxen_q;
        rxrdy_d    = rxrdy_q;
        rxdata_d   = rxdata_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;

        if (wr) begin
            case (bus.addr)
                A_DIV:   div_d  = bus.wdata[DIV_W-1:0];
                A_TXEN:  txen_d = bus.wdata[0];
                A_RXEN:  rxen_d = bus.wdata[0];
                default: ;
            endcase
        end

        case (tx_state_q)
            S_IDLE: if (wr && bus.addr == A_TXDATA && tx_rdy) begin
                tx_shift_d = bus.wdata[7:0];
                tx_cnt_d   = div_eff - 1'b1;
                txd_d      = 1'b0;
                tx_state_d = S_START;
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = div_eff - 1'b1;
                tx_bit_d   = 3'd0;
                txd_d      = tx_shift_q[0];
                tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q - 1'b1;
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = div_eff - 1'b1;
                if (tx_bit_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = S_STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    txd_d      = tx_shift_q[1];
                end
            end else tx_cnt_d = tx_cnt_q - 1'b1;
            S_STOP: if (tx_cnt_q == '0) tx_state_d = S_IDLE;
                    else tx_cnt_d = tx_cnt_q - 1'b1;
        endcase

        // A falling edge needs the line seen high first, so after a framing error we rearm only once it idles.
        case (rx_state_q)
            S_IDLE: if (rxen_q && !rx_s2_q && rx_prev_q) begin
                rx_cnt_d   = div_half - 1'b1;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = div_eff - 1'b1;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q - 1'b1;
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = div_eff - 1'b1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else rx_cnt_d = rx_cnt_q - 1'b1;
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d = S_IDLE;
                if (rx_s2_q) begin
                    rx_done  = 1'b1;
                    rxdata_d = rx_shift_q;
                end
            end else rx_cnt_d = rx_cnt_q - 1'b1;
        endcase

        if (rd && bus.addr == A_RXDATA) rxrdy_d = 1'b0;
        if (rx_done)                    rxrdy_d = 1'b1;

        if (wr && bus.addr == A_SRST && bus.wdata[0]) begin
            tx_state_d = S_IDLE;
            rx_state_d = S_IDLE;
            txd_d      = 1'b1;
            rxrdy_d    = 1'b0;
            txen_d     = 1'b0;
            rxen_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            div_q      <= '0;
            txen_q     <= 1'b0;
            rxen_q     <= 1'b0;
            rxrdy_q    <= 1'b0;
            rxdata_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            div_q      <= div_d;
            txen_q     <= txen_d;
            rxen_q     <= rxen_d;
            rxrdy_q    <= rxrdy_d;
            rxdata_q   <= rxdata_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end
endmodule
